srch_seg_sched: RTL
===================

// Module: srch_seg_sched
// PURPOSE
//  Sequencer for the 90 kHz segment search. On start it walks re_index 0..num_re-1 of one
//  symbol and streams one beat per RE over a valid/ready interface, tagging each with its
//  90k segment number and segment first/last markers. It sits between the search
//  controller (start/abort/config) and the per-segment correlation/accumulation datapath.
//  Segment tracking uses a modulo gap counter, not division.
// PARAMETERS
//  RE_W   8  width of RE index; max symbol length is 2**RE_W
//  SEG_W  4  width of segment number; segment saturates at 2**SEG_W-1
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous reset, active high
//  start          in   1        1-cycle pulse; latches scs/num_re, starts a scan (IDLE only)
//  abort          in   1        terminate scan, return to IDLE, no done
//  scs            in   2        0: single segment; 1: gap 18; 2: gap 6; 3: gap 3 REs
//  num_re         in   RE_W+1   REs to scan, 0..2**RE_W
//  busy           out  1        scan in progress (state RUN)
//  out_valid      out  1        beat valid
//  out_ready      in   1        downstream accepts beat
//  out_re_index   out  RE_W     RE index of beat
//  out_seg        out  SEG_W    90k segment of beat
//  out_seg_first  out  1        first RE of its segment
//  out_seg_last   out  1        last RE of its segment (or last RE of scan)
//  out_last       out  1        last beat of scan
//  done           out  1        1-cycle pulse after last beat accepted
//  seg_ovf        out  1        sticky: segment saturated this scan; cleared by start
// BEHAVIOUR
//  - Reset: state IDLE; busy, out_valid, out_seg_first, out_seg_last, out_last, done,
//    seg_ovf = 0; out_re_index, out_seg = 0; latched config = 0.
//  - States: IDLE, RUN, DONE. IDLE --start&!abort--> RUN (num_re!=0) or DONE (num_re==0).
//    RUN --last beat accepted--> DONE. DONE --1 cycle--> IDLE. Any state --abort--> IDLE.
//  - Latency: start at cycle t -> out_valid=1, out_re_index=0, out_seg=0 at t+1.
//  - Handshake: beat transfers when out_valid&out_ready. While out_valid&!out_ready, all
//    out_* hold stable. Throughput: 1 beat/cycle with out_ready held high.
//  - gap = 18/6/3 for scs 1/2/3. Gap counter g resets to 0 at scan start, increments per
//    accepted beat, wraps at gap-1. On wrap the segment increments, saturating at
//    2**SEG_W-1; seg_ovf sets when an increment is blocked by saturation.
//    Result: out_seg = min(floor(re/gap), 2**SEG_W-1).
//  - scs=0: no gap counter; out_seg=0 throughout; seg_first only at re 0.
//  - out_seg_first = (g==0). out_seg_last = (g==gap-1) | out_last.
//    out_last = (out_re_index==num_re-1).
//  - done: high exactly in DONE, the cycle after the last-beat transfer, or t+1 for
//    num_re==0. busy low in DONE; out_valid low in DONE and IDLE.
//  - start while busy or in DONE: ignored. scs/num_re are sampled only on an accepted start.
//  - abort has priority over start and over a same-cycle transfer. Next cycle: IDLE,
//    out_valid=0, no done. A subsequent start begins cleanly at re 0.
//  - rst mid-scan: identical to reset values next cycle.
//  - num_re=2**RE_W: index wraps to 0 after the last beat is never reached; out_last fires
//    at re 2**RE_W-1.
// TESTING
//  1. scs=3, num_re=12, ready=1 -> 12 beats on consecutive cycles, seg 0,0,0,1,1,1,2,2,2,3,3,3;
//     seg_first at re 0/3/6/9; seg_last at re 2/5/8/11; out_last and seg_last at re 11;
//     done 1 cycle later.
//  2. scs=1, num_re=256 -> re 17 seg 0 with seg_last; re 18 seg 1 with seg_first;
//     re 255 seg 14 with out_last; seg_ovf=0.
//  3. scs=3, num_re=64 -> seg reaches 15 at re 45 and holds to re 63; seg_ovf=1 from re 48;
//     next start clears seg_ovf.
//  4. scs=2, num_re=20, ready toggled 1,0,0,1... -> out_* stable while stalled; seq re 0..19,
//     seg 0..3, no beat lost or duplicated.
//  5. abort at re 5 with simultaneous start -> IDLE next cycle, no done; later start runs
//     re 0..num_re-1 normally; start during RUN ignored.
//  6. num_re=0 -> no beats, done at t+1; scs=0, num_re=7 -> seg 0 for all beats,
//     seg_first only at re 0, seg_last only at re 6.

Source files
------------

// File: rtl/srch_seg_sched.sv
// Segment-search RE sequencer: streams one beat per RE of a symbol, tagged with its
// 90 kHz segment number and segment boundary markers, using a modulo gap counter.
module srch_seg_sched #(
  parameter int RE_W  = 8,
  parameter int SEG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        scs,
  input  logic [RE_W:0]     num_re,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RE_W-1:0]   out_re_index,
  output logic [SEG_W-1:0]  out_seg,
  output logic              out_seg_first,
  output logic              out_seg_last,
  output logic              out_last,
  output logic              done,
  output logic              seg_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [SEG_W-1:0] SEG_MAX = '1;

  state_t           state, state_nxt;
  logic [RE_W-1:0]  re_idx;
  logic [SEG_W-1:0] seg;
  logic [4:0]       g;
  logic [4:0]       gap_m1;
  logic [1:0]       scs_q;
  logic [RE_W:0]    num_re_q;
  logic [RE_W:0]    last_idx;
  logic             ovf_q;
  logic             run;
  logic             wrap;
  logic             xfer;
  logic             start_ok;

  always_comb begin
    gap_m1 = 5'd0;
    case (scs_q)
      2'd1:    gap_m1 = 5'd17;
      2'd2:    gap_m1 = 5'd5;
      2'd3:    gap_m1 = 5'd2;
      default: gap_m1 = 5'd0;
    endcase
  end

  assign run      = (state == RUN);
  assign last_idx = num_re_q - (RE_W+1)'(1);
  assign wrap     = (scs_q != 2'd0) && (g == gap_m1);
  assign xfer     = run && out_ready && !abort;
  assign start_ok = (state == IDLE) && start && !abort;

  assign busy          = run;
  assign out_valid     = run;
  assign done          = (state == DONE);
  assign seg_ovf       = ovf_q;
  assign out_re_index  = re_idx;
  assign out_seg       = seg;
  assign out_last      = run && ({1'b0, re_idx} == last_idx);
  // With scs=0 there is no gap counter, so only the first RE opens a segment.
  assign out_seg_first = run && ((scs_q == 2'd0) ? (re_idx == '0) : (g == 5'd0));
  assign out_seg_last  = run && (wrap || out_last);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_nxt = (num_re == '0) ? DONE : RUN;
        RUN:  if (out_ready && out_last) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      re_idx   <= '0;
      seg      <= '0;
      g        <= '0;
      scs_q    <= '0;
      num_re_q <= '0;
      ovf_q    <= 1'b0;
    end else if (abort) begin
      re_idx <= '0;
      seg    <= '0;
      g      <= '0;
    end else if (start_ok) begin
      scs_q    <= scs;
      num_re_q <= num_re;
      re_idx   <= '0;
      seg      <= '0;
      g        <= '0;
      ovf_q    <= 1'b0;
    end else if (xfer) begin
      re_idx <= re_idx + RE_W'(1);
      if (scs_q != 2'd0) begin
        if (wrap) begin
          g <= '0;
          // Segment saturates; a blocked increment is remembered until the next start.
          if (seg == SEG_MAX) ovf_q <= 1'b1;
          else                seg   <= seg + SEG_W'(1);
        end else begin
          g <= g + 5'd1;
        end
      end
    end
  end

endmodule
